// File: rtl/vga_timing_pkg.sv
// Shared VGA horizontal timing definitions: FSM encodings, default width and
// sync polarity constants used by both the hsync generator and decoder.
package vga_timing_pkg;

   localparam int unsigned XRES_DEFAULT     = 10;
   localparam logic        SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic        SYNC_ACTIVE_HIGH = 1'b1;

   localparam int unsigned RG_SYNC     = 0;
   localparam int unsigned RG_BACK     = 1;
   localparam int unsigned RG_ACTIVE   = 2;
   localparam int unsigned RG_FRONT    = 3;
   localparam int unsigned NUM_REGIONS = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_BACK   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_FRONT  = 3'd4
   } hsync_state_e;

   function automatic logic hsync_asserted(input logic hs, input logic level);
      return (level == SYNC_ACTIVE_HIGH) ? hs : ~hs;
   endfunction

   // Counter slot belonging to a line region; IDLE has none and maps to slot 0.
   function automatic logic [1:0] region_of(input hsync_state_e st);
      case (st)
         ST_BACK:   return 2'(RG_BACK);
         ST_ACTIVE: return 2'(RG_ACTIVE);
         ST_FRONT:  return 2'(RG_FRONT);
         default:   return 2'(RG_SYNC);
      endcase
   endfunction

endpackage

// File: rtl/pixel_clock_oneshot.sv
// Brings the slow asynchronous PixelClock into the clock domain and emits a
// single-cycle pulse for each of its rising edges.
module pixel_clock_oneshot (
   input  logic clock,
   input  logic reset,
   input  logic PixelClock,
   output logic PixelClockOneShot
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= PixelClock;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign PixelClockOneShot = sync2_q & ~prev_q;

endmodule

// File: rtl/hsync_timing_decoder.sv
// Measures sync/back/active/front widths of an incoming hsync+DataEnable line,
// tracks lock and flags malformed lines. Define HSYNC_DEC_XPOS_EN for xposition.
module hsync_timing_decoder
   import vga_timing_pkg::*;
#(
   parameter int unsigned xresolution     = XRES_DEFAULT,
   parameter logic        SyncActiveLevel = SYNC_ACTIVE_LOW,
   parameter int unsigned LockLines       = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   PixelClock,
   input  logic                   hsync,
   input  logic                   DataEnable,
   output logic [xresolution-1:0] MeasSynchPulse,
   output logic [xresolution-1:0] MeasBackPorch,
   output logic [xresolution-1:0] MeasActiveVideo,
   output logic [xresolution-1:0] MeasFrontPorch,
   output logic                   LineStart,
   output logic                   Locked,
   output logic                   TimingError,
   output logic [xresolution-1:0] xposition
);

   localparam int unsigned            SW         = $clog2(LockLines + 1);
   localparam logic [SW-1:0]          LOCK_CNT   = SW'(LockLines);
   localparam logic [SW-1:0]          STABLE_ONE = SW'(1);
   localparam logic [xresolution-1:0] CNT_ONE    = xresolution'(1);
   // Saturation point: a count may never be allowed to become all-ones.
   localparam logic [xresolution-1:0] CNT_LAST   = ~xresolution'(1);

   typedef logic [NUM_REGIONS-1:0][xresolution-1:0] counts_t;

   logic         pix_tick, hs_act;
   hsync_state_e state_q, state_d;
   counts_t      cnt_q, cnt_d, meas_q, meas_d;
   logic [SW-1:0] stable_q, stable_d, stable_inc;
   logic         line_start_q, line_start_d, err_q, err_d;
   logic         malformed, overflow, stay;
   logic [1:0]   cur_rg;

   pixel_clock_oneshot u_oneshot (
      .clock             (clock),
      .reset             (reset),
      .PixelClock        (PixelClock),
      .PixelClockOneShot (pix_tick)
   );

   assign hs_act     = hsync_asserted(hsync, SyncActiveLevel);
   assign cur_rg     = region_of(state_q);
   assign stable_inc = (stable_q >= LOCK_CNT) ? stable_q : stable_q + STABLE_ONE;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      meas_d       = meas_q;
      stable_d     = stable_q;
      line_start_d = 1'b0;
      err_d        = 1'b0;
      malformed    = 1'b0;
      overflow     = 1'b0;
      stay         = 1'b0;
      if (pix_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (hs_act) begin
                  state_d         = ST_SYNC;
                  cnt_d[RG_SYNC]  = CNT_ONE;
               end
            end
            ST_SYNC: begin
               if (DataEnable) malformed = 1'b1;
               else if (!hs_act) begin
                  state_d         = ST_BACK;
                  cnt_d[RG_BACK]  = CNT_ONE;
               end else stay = 1'b1;
            end
            ST_BACK: begin
               if (hs_act) malformed = 1'b1;
               else if (DataEnable) begin
                  state_d          = ST_ACTIVE;
                  cnt_d[RG_ACTIVE] = CNT_ONE;
               end else stay = 1'b1;
            end
            ST_ACTIVE: begin
               if (hs_act) malformed = 1'b1;
               else if (!DataEnable) begin
                  state_d          = ST_FRONT;
                  cnt_d[RG_FRONT]  = CNT_ONE;
               end else stay = 1'b1;
            end
            ST_FRONT: begin
               if (hs_act) begin
                  state_d        = ST_SYNC;
                  cnt_d[RG_SYNC] = CNT_ONE;
                  meas_d         = cnt_q;
                  line_start_d   = 1'b1;
                  stable_d       = (cnt_q == meas_q) ? stable_inc : STABLE_ONE;
               end else stay = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase

         if (stay) begin
            if (cnt_q[cur_rg] == CNT_LAST) overflow = 1'b1;
            else cnt_d[cur_rg] = cnt_q[cur_rg] + CNT_ONE;
         end

         // A malformed line restarts measurement from a fresh sync when possible.
         if (malformed) begin
            err_d          = 1'b1;
            stable_d       = '0;
            state_d        = hs_act ? ST_SYNC : ST_IDLE;
            cnt_d[RG_SYNC] = CNT_ONE;
         end else if (overflow) begin
            err_d    = 1'b1;
            stable_d = '0;
            state_d  = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         meas_q       <= '0;
         stable_q     <= '0;
         line_start_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         meas_q       <= meas_d;
         stable_q     <= stable_d;
         line_start_q <= line_start_d;
         err_q        <= err_d;
      end
   end

   assign MeasSynchPulse  = meas_q[RG_SYNC];
   assign MeasBackPorch   = meas_q[RG_BACK];
   assign MeasActiveVideo = meas_q[RG_ACTIVE];
   assign MeasFrontPorch  = meas_q[RG_FRONT];
   assign LineStart       = line_start_q;
   assign TimingError     = err_q;
   assign Locked          = (stable_q >= LOCK_CNT);

`ifdef HSYNC_DEC_XPOS_EN
   logic [xresolution-1:0] xpos_q, xpos_d;

   always_comb begin
      xpos_d = xpos_q;
      if (pix_tick && state_d == ST_ACTIVE)
         xpos_d = (state_q == ST_ACTIVE) ? xpos_q + CNT_ONE : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) xpos_q <= '0;
      else        xpos_q <= xpos_d;
   end

   assign xposition = xpos_q;
`else
   assign xposition = '0;
`endif

endmodule

// File: tb/tb_hsync_timing_decoder.sv
// Randomised line-stream bench for hsync_timing_decoder with a pixel-level
// reference model of line measurement, lock and error behaviour.
module tb_hsync_timing_decoder;

   localparam logic SAL  = 1'b0;
   localparam int   MAXC = 1023;
   localparam int   LOCK = 2;
   localparam int   S_IDLE = 0, S_SYNC = 1, S_BACK = 2, S_ACT = 3, S_FRONT = 4;
   localparam int   NOF = 9;
`ifdef HSYNC_DEC_XPOS_EN
   localparam bit XPOS_ON = 1'b1;
`else
   localparam bit XPOS_ON = 1'b0;
`endif

   logic       clock = 1'b1;
   logic       reset = 1'b0;
   logic       PixelClock = 1'b0;
   logic       hsync = ~SAL;
   logic       DataEnable = 1'b0;
   logic [9:0] MeasSynchPulse, MeasBackPorch, MeasActiveVideo, MeasFrontPorch, xposition;
   logic       LineStart, Locked, TimingError;
   logic [39:0] meas_obs;

   int total = 0, bad = 0;
   int ls_obs = 0, te_obs = 0, lk_obs = 0, xs_obs = 0;
   int ls_exp = 0, te_exp = 0, lk_exp = 0, xs_exp = 0;

   // reference model state
   int m_st, m_run, m_stable, m_xpos;
   int m_len[4];
   int m_meas[4];
   bit m_ls, m_te;

   hsync_timing_decoder dut (
      .clock           (clock),
      .reset           (reset),
      .PixelClock      (PixelClock),
      .hsync           (hsync),
      .DataEnable      (DataEnable),
      .MeasSynchPulse  (MeasSynchPulse),
      .MeasBackPorch   (MeasBackPorch),
      .MeasActiveVideo (MeasActiveVideo),
      .MeasFrontPorch  (MeasFrontPorch),
      .LineStart       (LineStart),
      .Locked          (Locked),
      .TimingError     (TimingError),
      .xposition       (xposition)
   );

   assign meas_obs = {MeasSynchPulse, MeasBackPorch, MeasActiveVideo, MeasFrontPorch};

   always #1 clock = ~clock;
   initial begin
      #1;
      forever #4 PixelClock = ~PixelClock;
   end

   function automatic logic [39:0] m_vec();
      return {10'(m_meas[0]), 10'(m_meas[1]), 10'(m_meas[2]), 10'(m_meas[3])};
   endfunction

   function automatic logic [39:0] vec4(input int s, input int b, input int a, input int f);
      return {10'(s), 10'(b), 10'(a), 10'(f)};
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_run = 0; m_stable = 0; m_xpos = 0;
      for (int i = 0; i < 4; i++) begin m_len[i] = 0; m_meas[i] = 0; end
   endtask

   // One pixel of the line grammar: track the length of the current region and
   // publish the four lengths whenever a new sync pulse closes the line.
   task automatic model_step(input bit hs, input bit de);
      bit err, same;
      err = 0; m_ls = 0; m_te = 0;
      case (m_st)
         S_IDLE:  if (hs) begin m_st = S_SYNC; m_run = 1; end
         S_SYNC:  if (de) err = 1;
                  else if (!hs) begin m_len[0] = m_run; m_st = S_BACK; m_run = 1; end
                  else m_run++;
         S_BACK:  if (hs) err = 1;
                  else if (de) begin m_len[1] = m_run; m_st = S_ACT; m_run = 1; m_xpos = 0; end
                  else m_run++;
         S_ACT:   if (hs) err = 1;
                  else if (!de) begin m_len[2] = m_run; m_st = S_FRONT; m_run = 1; end
                  else begin m_run++; if (m_run < MAXC) m_xpos++; end
         default: if (hs) begin
                     m_len[3] = m_run;
                     same = 1;
                     for (int i = 0; i < 4; i++) if (m_len[i] != m_meas[i]) same = 0;
                     m_stable = same ? m_stable + 1 : 1;
                     for (int i = 0; i < 4; i++) m_meas[i] = m_len[i];
                     m_ls = 1; m_st = S_SYNC; m_run = 1;
                  end else m_run++;
      endcase
      if (err) begin
         m_te = 1; m_stable = 0; m_st = hs ? S_SYNC : S_IDLE; m_run = 1;
      end else if (m_st != S_IDLE && m_run >= MAXC) begin
         m_te = 1; m_stable = 0; m_st = S_IDLE; m_run = 0;
      end
   endtask

   // Drive one pixel on the PixelClock rise; observe 6 ns later, after the
   // decoder has acted on it and before the next pixel is presented.
   task automatic pix(input bit hs, input bit de);
      @(posedge PixelClock);
      hsync = hs ? SAL : ~SAL;
      DataEnable = de;
      if (reset) model_step(hs, de);
      #6;
      if (reset) begin
         ls_obs += int'(LineStart);  ls_exp += int'(m_ls);
         te_obs += int'(TimingError); te_exp += int'(m_te);
         lk_obs += int'(Locked);     lk_exp += (m_stable >= LOCK) ? 1 : 0;
         xs_obs += int'(xposition);  xs_exp += XPOS_ON ? m_xpos : 0;
      end
   endtask

   // back, active, front, then the next sync pulse (whose first pixel closes the line)
   task automatic line(input int b, input int a, input int f, input int s, input int fault);
      for (int i = 0; i < b; i++) pix(1'b0, fault == 2 && i == 0);
      for (int i = 0; i < a; i++) pix(fault == 0 && i == a / 2, 1'b1);
      for (int i = 0; i < f; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < s; i++) pix(1'b1, fault == 1 && i == s - 1);
   endtask

   task automatic test_reset();
      model_reset();
      @(posedge PixelClock);
      #6;
      reset = 1'b1;
      #1;
      total++; if (meas_obs !== 40'd0) begin bad++; $display("FAIL reset_meas: got %h want 0", meas_obs); end
      total++; if ({Locked, LineStart, TimingError} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {Locked, LineStart, TimingError}); end
      total++; if (xposition !== 10'd0) begin bad++; $display("FAIL reset_xpos: got %0d want 0", xposition); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 3; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pix(1'b1, 1'b0);
      for (int n = 0; n < 4; n++) begin
         line(4, 6, 2, 3, NOF);
         total++; if (meas_obs !== vec4(3, 4, 6, 2)) begin bad++; $display("FAIL basic_meas line %0d: got %h want %h", n, meas_obs, vec4(3, 4, 6, 2)); end
         total++; if (Locked !== (m_stable >= LOCK)) begin bad++; $display("FAIL basic_lock line %0d: got %b want %b", n, Locked, m_stable >= LOCK); end
      end
      total++; if (Locked !== 1'b1) begin bad++; $display("FAIL basic_locked: got %b want 1", Locked); end
      total++; if (xposition !== (XPOS_ON ? 10'd5 : 10'd0)) begin bad++; $display("FAIL basic_xpos: got %0d want %0d", xposition, XPOS_ON ? 5 : 0); end
      total++; if (ls_obs !== ls_exp || ls_exp !== 4) begin bad++; $display("FAIL basic_linestart: got %0d want %0d (4)", ls_obs, ls_exp); end
      total++; if (xs_obs !== xs_exp) begin bad++; $display("FAIL basic_xpos_hist: got %0d want %0d", xs_obs, xs_exp); end
   endtask

   task automatic test_active_change();
      line(4, 8, 2, 3, NOF);
      total++; if (MeasActiveVideo !== 10'd8) begin bad++; $display("FAIL chg_active: got %0d want 8", MeasActiveVideo); end
      total++; if (Locked !== 1'b0) begin bad++; $display("FAIL chg_unlock: got %b want 0", Locked); end
      line(4, 8, 2, 3, NOF);
      total++; if (Locked !== 1'b1) begin bad++; $display("FAIL chg_relock: got %b want 1", Locked); end
      total++; if (lk_obs !== lk_exp) begin bad++; $display("FAIL chg_lock_hist: got %0d want %0d", lk_obs, lk_exp); end
   endtask

   task automatic test_hsync_in_active();
      for (int i = 0; i < 4; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pix(1'b0, 1'b1);
      pix(1'b1, 1'b1);
      total++; if (TimingError !== 1'b1) begin bad++; $display("FAIL hsact_err: got %b want 1", TimingError); end
      total++; if (Locked !== 1'b0) begin bad++; $display("FAIL hsact_lock: got %b want 0", Locked); end
      total++; if (meas_obs !== vec4(3, 4, 8, 2)) begin bad++; $display("FAIL hsact_meas: got %h want %h", meas_obs, vec4(3, 4, 8, 2)); end
      pix(1'b1, 1'b0); pix(1'b1, 1'b0);
      line(4, 8, 2, 3, NOF);
      total++; if (meas_obs !== m_vec()) begin bad++; $display("FAIL hsact_after: got %h want %h", meas_obs, m_vec()); end
      total++; if (te_obs !== te_exp) begin bad++; $display("FAIL hsact_errcount: got %0d want %0d", te_obs, te_exp); end
   endtask

   task automatic test_overflow();
      int te0;
      te0 = te_obs;
      for (int i = 0; i < 4; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) pix(1'b0, 1'b1);
      for (int i = 0; i < 1024; i++) pix(1'b0, 1'b0);
      total++; if (te_obs - te0 !== 1) begin bad++; $display("FAIL ovf_err: got %0d pulses want 1", te_obs - te0); end
      total++; if (Locked !== 1'b0) begin bad++; $display("FAIL ovf_lock: got %b want 0", Locked); end
      for (int i = 0; i < 3; i++) pix(1'b1, 1'b0);
      line(4, 8, 2, 3, NOF);
      total++; if (Locked !== 1'b0) begin bad++; $display("FAIL ovf_lock1: got %b want 0", Locked); end
      line(4, 8, 2, 3, NOF);
      total++; if (Locked !== 1'b1) begin bad++; $display("FAIL ovf_lock2: got %b want 1", Locked); end
      total++; if (te_obs !== te_exp) begin bad++; $display("FAIL ovf_errcount: got %0d want %0d", te_obs, te_exp); end
   endtask

   task automatic test_reset_mid_active();
      for (int i = 0; i < 4; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pix(1'b0, 1'b1);
      reset = 1'b0;
      #1;
      total++; if ({meas_obs, Locked, LineStart, TimingError, xposition} !== 53'd0) begin bad++; $display("FAIL rst_async: got %h want 0", {meas_obs, Locked, LineStart, TimingError, xposition}); end
      model_reset();
      for (int i = 0; i < 3; i++) pix(1'b0, 1'b1);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) pix(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) pix(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) pix(1'b1, 1'b0);
      total++; if (meas_obs !== 40'd0) begin bad++; $display("FAIL rst_first_sync: got %h want 0", meas_obs); end
      line(4, 6, 2, 3, NOF);
      total++; if (meas_obs !== vec4(3, 4, 6, 2)) begin bad++; $display("FAIL rst_second_sync: got %h want %h", meas_obs, vec4(3, 4, 6, 2)); end
   endtask

   task automatic test_random();
      int b, a, f, s, fault;
      b = 3; a = 5; f = 2; s = 3;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            b = $urandom_range(1, 6); a = $urandom_range(1, 8);
            f = $urandom_range(1, 4); s = $urandom_range(1, 4);
         end
         fault = $urandom_range(0, 7);
         line(b, a, f, s, fault);
         total++; if (meas_obs !== m_vec()) begin bad++; $display("FAIL rnd_meas line %0d: got %h want %h", n, meas_obs, m_vec()); end
         total++; if (Locked !== (m_stable >= LOCK)) begin bad++; $display("FAIL rnd_lock line %0d: got %b want %b", n, Locked, m_stable >= LOCK); end
      end
      total++; if (ls_obs !== ls_exp) begin bad++; $display("FAIL rnd_linestart: got %0d want %0d", ls_obs, ls_exp); end
      total++; if (te_obs !== te_exp) begin bad++; $display("FAIL rnd_errcount: got %0d want %0d", te_obs, te_exp); end
      total++; if (lk_obs !== lk_exp) begin bad++; $display("FAIL rnd_lock_hist: got %0d want %0d", lk_obs, lk_exp); end
      total++; if (xs_obs !== xs_exp) begin bad++; $display("FAIL rnd_xpos_hist: got %0d want %0d", xs_obs, xs_exp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_active_change();
      test_hsync_in_active();
      test_overflow();
      test_reset_mid_active();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
